// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU, branch target, and the EX/MEM pipeline register.
// Define M_EXT_EN to compile in the iterative MUL/DIV/REM unit and its stall FSM.
module execute_stage #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_valid,
    input  logic                  i_flush,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic [ADDR_WIDTH-1:0] i_pc_plus4,
    input  logic [DATA_WIDTH-1:0] i_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_rs2_data,
    input  logic [DATA_WIDTH-1:0] i_imm_ext,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    input  logic                  i_alu_src,
    input  logic [4:0]            i_alu_control,
    input  logic [2:0]            i_result_src,
    input  logic                  i_mem_we,
    input  logic                  i_reg_we,
    output logic                  o_stall,
    output logic [ADDR_WIDTH-1:0] o_pc_plus4,
    output logic [ADDR_WIDTH-1:0] o_pc_target,
    output logic [DATA_WIDTH-1:0] o_alu_result,
    output logic [DATA_WIDTH-1:0] o_write_data,
    output logic [DATA_WIDTH-1:0] o_imm_ext,
    output logic [REG_ADDR_W-1:0] o_rd_addr,
    output logic [2:0]            o_result_src,
    output logic                  o_mem_we,
    output logic                  o_reg_we
);

    localparam int SHW = $clog2(DATA_WIDTH);

    logic        [DATA_WIDTH-1:0] opb_p0;
    logic signed [DATA_WIDTH-1:0] rs1_s_p0;
    logic signed [DATA_WIDTH-1:0] opb_s_p0;
    logic        [SHW-1:0]        shamt_p0;
    logic        [DATA_WIDTH-1:0] alu_res_p0;
    logic        [DATA_WIDTH-1:0] result_p0;
    logic        [ADDR_WIDTH-1:0] target_p0;
    logic                         vld_p0;
    logic                         stall;

    // ---- stage p0: operand select, ALU, branch target ----
    assign opb_p0    = i_alu_src ? i_imm_ext : i_rs2_data;
    assign rs1_s_p0  = i_rs1_data;
    assign opb_s_p0  = opb_p0;
    assign shamt_p0  = opb_p0[SHW-1:0];
    assign target_p0 = i_pc + ADDR_WIDTH'(i_imm_ext);

    always_comb begin
        alu_res_p0 = '0;
        case (i_alu_control)
            5'd0: alu_res_p0 = i_rs1_data + opb_p0;
            5'd1: alu_res_p0 = i_rs1_data - opb_p0;
            5'd2: alu_res_p0 = i_rs1_data & opb_p0;
            5'd3: alu_res_p0 = i_rs1_data | opb_p0;
            5'd4: alu_res_p0 = i_rs1_data ^ opb_p0;
            5'd5: alu_res_p0 = i_rs1_data << shamt_p0;
            5'd6: alu_res_p0 = i_rs1_data >> shamt_p0;
            5'd7: alu_res_p0 = rs1_s_p0 >>> shamt_p0;
            5'd8: alu_res_p0 = {{(DATA_WIDTH-1){1'b0}}, rs1_s_p0 < opb_s_p0};
            5'd9: alu_res_p0 = {{(DATA_WIDTH-1){1'b0}}, i_rs1_data < opb_p0};
            default: alu_res_p0 = '0;
        endcase
    end

`ifdef M_EXT_EN
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [DATA_WIDTH-1:0]   acc_q, opa_q, opb_q;
    logic                    mul_mode_q, quo_neg_q, rem_neg_q, div_zero_q;
    logic                    is_iter, is_signed_div, accept;
    logic [DATA_WIDTH:0]     rem_sh;
    logic                    fits;
    logic [DATA_WIDTH-1:0]   iter_res;

    function automatic logic [DATA_WIDTH-1:0] apply_sign(input logic [DATA_WIDTH-1:0] mag,
                                                         input logic neg);
        return neg ? -mag : mag;
    endfunction

    assign is_iter       = (i_alu_control == 5'd16) ||
                           (i_alu_control >= 5'd18 && i_alu_control <= 5'd21);
    assign is_signed_div = (i_alu_control == 5'd18) || (i_alu_control == 5'd20);
    assign accept        = (state_q == IDLE) && i_valid && is_iter && !i_flush && !i_arst;

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                state_d = BUSY;
                stall   = 1'b1;
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (i_flush) state_d = IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (i_flush)                cnt_q <= '0;
            else if (accept)            cnt_q <= CNT_W'(DATA_WIDTH);
            else if (state_q == BUSY)   cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Restoring-divide step: remainder shifts in the next dividend bit from opa.
    assign rem_sh = {acc_q, opa_q[DATA_WIDTH-1]};
    assign fits   = rem_sh[DATA_WIDTH] || (rem_sh[DATA_WIDTH-1:0] >= opb_q);

    always_ff @(posedge i_clk) begin
        if (accept) begin
            mul_mode_q <= (i_alu_control == 5'd16);
            quo_neg_q  <= is_signed_div && (i_rs1_data[DATA_WIDTH-1] ^ opb_p0[DATA_WIDTH-1]);
            rem_neg_q  <= is_signed_div && i_rs1_data[DATA_WIDTH-1];
            div_zero_q <= (opb_p0 == '0);
            acc_q      <= '0;
            opa_q      <= apply_sign(i_rs1_data, is_signed_div && i_rs1_data[DATA_WIDTH-1]);
            opb_q      <= apply_sign(opb_p0, is_signed_div && opb_p0[DATA_WIDTH-1]);
        end else if (state_q == BUSY) begin
            if (mul_mode_q) begin
                acc_q <= acc_q + (opa_q[0] ? opb_q : '0);
                opa_q <= opa_q >> 1;
                opb_q <= opb_q << 1;
            end else begin
                acc_q <= fits ? (rem_sh[DATA_WIDTH-1:0] - opb_q) : rem_sh[DATA_WIDTH-1:0];
                opa_q <= {opa_q[DATA_WIDTH-2:0], fits};
            end
        end
    end

    always_comb begin
        iter_res = '0;
        case (i_alu_control)
            5'd16:        iter_res = acc_q;
            5'd18, 5'd19: iter_res = div_zero_q ? '1 : apply_sign(opa_q, quo_neg_q);
            5'd20, 5'd21: iter_res = apply_sign(acc_q, rem_neg_q);
            default:      iter_res = '0;
        endcase
    end

    assign result_p0 = (state_q == DONE) ? iter_res : alu_res_p0;
`else
    assign stall     = 1'b0;
    assign result_p0 = alu_res_p0;
`endif

    assign o_stall = stall;
    assign vld_p0  = i_valid && !i_flush && !stall;

    // ---- stage p1: EX/MEM pipeline register ----
    always_ff @(posedge i_clk) begin
        if (i_arst || i_flush || stall) begin
            o_pc_plus4   <= '0;
            o_pc_target  <= '0;
            o_alu_result <= '0;
            o_write_data <= '0;
            o_imm_ext    <= '0;
            o_rd_addr    <= '0;
            o_result_src <= '0;
            o_mem_we     <= 1'b0;
            o_reg_we     <= 1'b0;
        end else begin
            o_pc_plus4   <= i_pc_plus4;
            o_pc_target  <= target_p0;
            o_alu_result <= result_p0;
            o_write_data <= i_rs2_data;
            o_imm_ext    <= i_imm_ext;
            o_rd_addr    <= i_rd_addr;
            o_result_src <= i_result_src;
            o_mem_we     <= i_mem_we && vld_p0;
            o_reg_we     <= i_reg_we && vld_p0;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed-vector bench for execute_stage; iterative cases follow the M_EXT_EN build.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        arst, valid, flush, alu_src, mem_we, reg_we, stall;
    logic [63:0] pc, pc_plus4, rs1, rs2, imm;
    logic [4:0]  rd, ctrl;
    logic [2:0]  result_src;
    logic [63:0] o_pc_plus4, o_pc_target, o_alu_result, o_write_data, o_imm_ext;
    logic [4:0]  o_rd_addr;
    logic [2:0]  o_result_src;
    logic        o_mem_we, o_reg_we;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    execute_stage dut (
        .i_clk(clk), .i_arst(arst), .i_valid(valid), .i_flush(flush),
        .i_pc(pc), .i_pc_plus4(pc_plus4), .i_rs1_data(rs1), .i_rs2_data(rs2),
        .i_imm_ext(imm), .i_rd_addr(rd), .i_alu_src(alu_src), .i_alu_control(ctrl),
        .i_result_src(result_src), .i_mem_we(mem_we), .i_reg_we(reg_we),
        .o_stall(stall), .o_pc_plus4(o_pc_plus4), .o_pc_target(o_pc_target),
        .o_alu_result(o_alu_result), .o_write_data(o_write_data), .o_imm_ext(o_imm_ext),
        .o_rd_addr(o_rd_addr), .o_result_src(o_result_src), .o_mem_we(o_mem_we),
        .o_reg_we(o_reg_we)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic src, input logic [63:0] im);
        valid = 1'b1; ctrl = op; rs1 = a; rs2 = b; alu_src = src; imm = im;
    endtask

    task automatic run_alu(input string tag, input logic [4:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] exp);
        set_op(op, a, b, 1'b0, 64'd0);
        step();
        check_eq(tag, o_alu_result, exp);
    endtask

    task automatic run_iter(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                            output logic [63:0] res, output int stalls, output int bubble_errs);
        set_op(op, a, b, 1'b0, 64'd0);
        reg_we = 1'b1; rd = 5'd9;
        #1;
        stalls = 0;
        bubble_errs = 0;
        while (stall === 1'b1 && stalls < 200) begin
            stalls++;
            step();
            if (o_reg_we !== 1'b0 || o_alu_result !== 64'd0) bubble_errs++;
        end
        step();
        res = o_alu_result;
        valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] res;
        int          n, bub;

        arst = 1'b1; valid = 1'b0; flush = 1'b0; alu_src = 1'b0; mem_we = 1'b0;
        reg_we = 1'b0; pc = 64'h1000; pc_plus4 = 64'h1004; rs1 = '0; rs2 = '0;
        imm = '0; rd = '0; ctrl = '0; result_src = '0;
        step();
        step();
        check_eq("rst_alu", o_alu_result, 64'd0);
        check_eq("rst_reg_we", {63'd0, o_reg_we}, 64'd0);
        check_eq("rst_target", o_pc_target, 64'd0);
        check_eq("rst_stall", {63'd0, stall}, 64'd0);
        arst = 1'b0;

        // ADD with immediate
        set_op(5'd0, 64'd5, 64'hAA, 1'b1, 64'd7);
        rd = 5'd3; reg_we = 1'b1; result_src = 3'd2;
        step();
        check_eq("add_res", o_alu_result, 64'd12);
        check_eq("add_rd", {59'd0, o_rd_addr}, 64'd3);
        check_eq("add_we", {63'd0, o_reg_we}, 64'd1);
        check_eq("add_target", o_pc_target, 64'h1007);
        check_eq("add_pc4", o_pc_plus4, 64'h1004);
        check_eq("add_wdata", o_write_data, 64'hAA);
        check_eq("add_rsrc", {61'd0, o_result_src}, 64'd2);

        run_alu("sra", 5'd7, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000);
        run_alu("srl", 5'd6, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000);
        run_alu("sltu", 5'd9, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        run_alu("slt_pos", 5'd8, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        run_alu("slt_neg", 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1);
        run_alu("sll_wrap", 5'd5, 64'd3, 64'd65, 64'd6);
        run_alu("sub", 5'd1, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE);
        run_alu("xor", 5'd4, 64'hF0F0, 64'h0FF0, 64'hFF00);
        run_alu("bad_code", 5'd10, 64'd5, 64'd7, 64'd0);

        // invalid instruction keeps its data but suppresses writes
        set_op(5'd0, 64'd1, 64'd1, 1'b0, 64'd0);
        valid = 1'b0; mem_we = 1'b1;
        step();
        check_eq("invalid_we", {62'd0, o_reg_we, o_mem_we}, 64'd0);
        mem_we = 1'b0;

        // flush turns the instruction into a bubble
        set_op(5'd0, 64'd1, 64'd1, 1'b0, 64'd0);
        flush = 1'b1;
        step();
        check_eq("flush_res", o_alu_result, 64'd0);
        check_eq("flush_we", {63'd0, o_reg_we}, 64'd0);
        flush = 1'b0;

`ifdef M_EXT_EN
        run_iter(5'd16, 64'h1_0000_0001, 64'd3, res, n, bub);
        check_eq("mul_stall_cycles", 64'(n), 64'd65);
        check_eq("mul_bubbles", 64'(bub), 64'd0);
        check_eq("mul_res", res, 64'h3_0000_0003);
        check_eq("mul_we", {63'd0, o_reg_we}, 64'd1);
        check_eq("mul_rd", {59'd0, o_rd_addr}, 64'd9);

        run_iter(5'd18, -64'sd7, 64'd2, res, n, bub);
        check_eq("div_neg", res, -64'sd3);
        run_iter(5'd20, -64'sd7, 64'd2, res, n, bub);
        check_eq("rem_neg", res, -64'sd1);
        run_iter(5'd19, 64'd123, 64'd0, res, n, bub);
        check_eq("divu_zero", res, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("divu_zero_cycles", 64'(n), 64'd65);
        run_iter(5'd21, 64'd123, 64'd0, res, n, bub);
        check_eq("remu_zero", res, 64'd123);
        run_iter(5'd20, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, res, n, bub);
        check_eq("rem_ovf", res, 64'd0);
        run_iter(5'd18, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, res, n, bub);
        check_eq("div_ovf", res, 64'h8000_0000_0000_0000);
        run_iter(5'd19, 64'd100, 64'd7, res, n, bub);
        check_eq("divu", res, 64'd14);

        // abort a DIVU after 10 busy cycles
        set_op(5'd19, 64'd1000, 64'd3, 1'b0, 64'd0);
        for (int i = 0; i < 10; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        set_op(5'd0, 64'd20, 64'd22, 1'b0, 64'd0);
        #1;
        check_eq("abort_stall", {63'd0, stall}, 64'd0);
        check_eq("abort_bubble", o_alu_result, 64'd0);
        step();
        check_eq("abort_add", o_alu_result, 64'd42);

        // reset in the middle of a MUL
        set_op(5'd16, 64'd7, 64'd6, 1'b0, 64'd0);
        for (int i = 0; i < 5; i++) step();
        arst = 1'b1;
        step();
        check_eq("rst_busy_stall", {63'd0, stall}, 64'd0);
        check_eq("rst_busy_res", o_alu_result, 64'd0);
        check_eq("rst_busy_we", {63'd0, o_reg_we}, 64'd0);
        arst = 1'b0;
        valid = 1'b0;
        step();
`else
        set_op(5'd16, 64'h1_0000_0001, 64'd3, 1'b0, 64'd0);
        #1;
        check_eq("mul_nostall", {63'd0, stall}, 64'd0);
        step();
        check_eq("mul_zero", o_alu_result, 64'd0);
        check_eq("mul_we", {63'd0, o_reg_we}, 64'd1);
        run_alu("div_zero", 5'd18, 64'd100, 64'd7, 64'd0);
        check_eq("div_nostall", {63'd0, stall}, 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 64-bit in-order pipeline, sitting between decode and `memory_stage`. It computes single-cycle ALU results and the branch/jump target `pc + imm`, and runs optional multi-cycle MUL/DIV/REM on a shared iterative datapath. While an iterative operation is running it stalls the upstream stages. It also owns the execute/memory pipeline register whose outputs drive `memory_stage` directly.

## Interface
- `ADDR_WIDTH`, 64, PC width
- `DATA_WIDTH`, 64, operand/result width (iterative unit runs `DATA_WIDTH` steps)
- `REG_ADDR_W`, 5, register-file address width

- `i_clk`  in  1  clock, all state on rising edge
- `i_arst`  in  1  reset; synchronous, active-high
- `i_valid`  in  1  instruction present on inputs
- `i_flush`  in  1  kill the current instruction and any running iterative op
- `i_pc`, `i_pc_plus4`  in  ADDR_WIDTH  instruction PC, PC+4
- `i_rs1_data`, `i_rs2_data`  in  DATA_WIDTH  forwarded operands
- `i_imm_ext`  in  DATA_WIDTH  extended immediate
- `i_rd_addr`  in  REG_ADDR_W  destination register
- `i_alu_src`  in  1  operand B select: 0 = rs2, 1 = imm
- `i_alu_control`  in  5  operation code (see Operation)
- `i_result_src`  in  3  passed through
- `i_mem_we`, `i_reg_we`  in  1  passed through
- `o_stall`  out  1  hold upstream stages (combinational)
- `o_pc_plus4`, `o_pc_target`  out  ADDR_WIDTH  registered
- `o_alu_result`, `o_write_data`, `o_imm_ext`  out  DATA_WIDTH  registered; `o_write_data` = rs2
- `o_rd_addr`  out  REG_ADDR_W  registered
- `o_result_src`  out  3  registered
- `o_mem_we`, `o_reg_we`  out  1  registered

## Operation
- Single-cycle codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
  - Shift amount = B[5:0].
  - SLT/SLTU produce 1 or 0, zero-extended.
- Iterative codes: 16 MUL (low 64 bits of the product), 18 DIV, 19 DIVU, 20 REM, 21 REMU. All other codes produce a result of 0.
- Target: `o_pc_target` is always computed as `i_pc + i_imm_ext`, modulo 2^ADDR_WIDTH.
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY when `i_valid && iterative code && !i_flush`. Load operands; step counter = DATA_WIDTH.
  - BUSY: one shift-add (MUL) or restoring-divide step per cycle; counter decrements. At counter 1 -> DONE.
  - DONE -> IDLE unconditionally. The result is loaded into the pipeline register at this edge.
- `o_stall` = (IDLE and an iterative op is being accepted) or BUSY. It is low in DONE.
- Signed DIV/REM: operate on magnitudes, then fix signs. The quotient is negative when operand signs differ; the remainder takes the dividend's sign.
- Divide by zero: quotient = all ones, remainder = dividend. No stall shortening.
- Signed overflow (most-negative / -1): quotient = dividend, remainder = 0.
- Pipeline register update, in priority order:
  1. reset;
  2. `i_flush` or `o_stall`: load a bubble (all fields 0, `reg_we` = `mem_we` = 0);
  3. otherwise: load the computed values, with `reg_we`/`mem_we` gated by `i_valid`.

## Timing
- Reset: every output is 0, the FSM is IDLE, the counter is 0, and `o_stall` is 0.
- Single-cycle op presented in cycle N: results appear on the outputs in cycle N+1.
- Iterative op presented in cycle N:
  - `o_stall` is high in cycles N..N+DATA_WIDTH (65 cycles at default);
  - DONE occurs in cycle N+DATA_WIDTH+1;
  - the result appears in cycle N+DATA_WIDTH+2;
  - bubbles reach `memory_stage` during the stall.
- Upstream holds every input stable while `o_stall` = 1. The block samples the opcode, rd and control signals again in DONE.
- Flush in BUSY or DONE: FSM -> IDLE next cycle, a bubble is loaded, and `o_stall` is low from the next cycle. The partial result is discarded.
- Reset mid-operation behaves the same as a flush, and additionally clears all outputs.
- Back-to-back iterative ops: the second is accepted from IDLE in the cycle after DONE.

## Configuration
- `M_EXT_EN` defined: iterative unit, FSM and stall logic are compiled in.
- `M_EXT_EN` undefined:
  - codes 16–21 are treated as single-cycle and produce 0;
  - `o_stall` is tied to 0;
  - the FSM and counter are absent.

## Test plan
- ADD: rs1 = 5, imm = 7, alu_src = 1, rd = 3, reg_we = 1 -> next cycle `o_alu_result` = 12, `o_rd_addr` = 3, `o_reg_we` = 1; `o_pc_target` = pc + 7.
- SRA: rs1 = 0x8000_0000_0000_0000, rs2 = 4 -> 0xF800_0000_0000_0000. SLTU with 1 vs −1 -> 1.
- MUL: 0x1_0000_0001 × 3 -> `o_stall` high exactly 65 cycles, bubbles during the stall; then `o_alu_result` = 0x3_0000_0003 with `o_reg_we` = 1.
- DIV edge cases:
  - −7 / 2 -> quotient −3; REM of the same operands -> −1;
  - DIVU by 0 -> 0xFFFF_FFFF_FFFF_FFFF;
  - REM of 0x8000…0 by −1 -> 0.
- Abort: `i_flush` 10 cycles into a DIVU -> the next cycle has `o_stall` = 0 and a bubble on the outputs; a following ADD completes normally.
- Reset asserted during BUSY -> all outputs 0 and `o_stall` = 0 on the next cycle; with `M_EXT_EN` undefined, MUL gives result 0 and `o_stall` never rises.
